// File: rtl/aud_rec_writer.sv
// I2S ADC record path: deserialises left-channel samples and writes them to SRAM at consecutive addresses.
// Optional AUD_REC_STEREO_AVG_EN: also captures the right word and writes the average of L and R.
module aud_rec_writer #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 20,
    parameter int MAX_ADDR = 1024000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_bclk,
    input  logic              i_lrck,
    input  logic              i_adcdat,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_stop_addr,
    output logic              o_fin,
    output logic [2:0]        o_state
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_SHIFT = 3'd2,
        S_WRITE = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    state_t             r_state, w_next;
    logic               r_bclk_prev, r_lrck_prev;
    logic [CNT_W-1:0]   r_bitcnt;
    logic               r_skip;
    logic [DATA_W-1:0]  r_shift;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_stop_addr;
    logic               r_fin;
    logic               r_pend_stop, r_pend_pause;

    logic               w_bclk_rise, w_lrck_fall, w_frame_edge;
    logic               w_stop, w_pause;
    logic               w_capture, w_word_done, w_to_write;
    logic               w_stop_take;
    logic [ADDR_W-1:0]  w_addr_inc;
    logic               w_last;
    logic [DATA_W-1:0]  w_shift_in;

    assign w_bclk_rise = ~r_bclk_prev & i_bclk;
    assign w_lrck_fall = r_lrck_prev & ~i_lrck;
    // Pending flags only live for the single cycle after a write.
    assign w_stop      = i_stop | r_pend_stop;
    assign w_pause     = i_pause | r_pend_pause;
    assign w_capture   = (r_state == S_SHIFT) & w_bclk_rise & ~r_skip;
    assign w_word_done = w_capture & (r_bitcnt == CNT_W'(DATA_W - 1));
    assign w_shift_in  = {r_shift[DATA_W-2:0], i_adcdat};
    assign w_addr_inc  = r_addr + 1'b1;
    assign w_last      = (w_addr_inc == ADDR_W'(MAX_ADDR));

`ifdef AUD_REC_STEREO_AVG_EN
    logic                r_right;
    logic [DATA_W-1:0]   r_left;
    logic                w_lrck_rise;
    logic signed [DATA_W:0] w_sum;

    assign w_lrck_rise  = ~r_lrck_prev & i_lrck;
    assign w_frame_edge = r_right ? w_lrck_rise : w_lrck_fall;
    assign w_to_write   = w_word_done & r_right;
    // 17-bit sum keeps the carry; dropping bit 0 is the arithmetic shift.
    assign w_sum        = $signed({r_left[DATA_W-1], r_left}) + $signed({r_shift[DATA_W-1], r_shift});
    assign o_data       = w_sum[DATA_W:1];
`else
    assign w_frame_edge = w_lrck_fall;
    assign w_to_write   = w_word_done;
    assign o_data       = r_shift;
`endif

    always_comb begin
        w_next      = r_state;
        w_stop_take = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_stop) begin
                    w_next      = S_IDLE;
                    w_stop_take = 1'b1;
                end else if (w_pause) begin
                    w_next = S_PAUSE;
                end else if (w_frame_edge) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (i_stop) begin
                    w_next      = S_IDLE;
                    w_stop_take = 1'b1;
                end else if (i_pause) begin
                    w_next = S_PAUSE;
                end else if (w_to_write) begin
                    w_next = S_WRITE;
                end else if (w_word_done) begin
                    w_next = S_WAIT;
                end
            end
            S_WRITE: begin
                w_next = w_last ? S_IDLE : S_WAIT;
            end
            S_PAUSE: begin
                if (i_stop) begin
                    w_next      = S_IDLE;
                    w_stop_take = 1'b1;
                end else if (i_start) begin
                    w_next = S_WAIT;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_bclk_prev  <= 1'b0;
            r_lrck_prev  <= 1'b0;
            r_bitcnt     <= '0;
            r_skip       <= 1'b0;
            r_shift      <= '0;
            r_addr       <= '0;
            r_stop_addr  <= '0;
            r_fin        <= 1'b0;
            r_pend_stop  <= 1'b0;
            r_pend_pause <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_bclk_prev  <= i_bclk;
            r_lrck_prev  <= i_lrck;
            r_pend_stop  <= (r_state == S_WRITE) & i_stop;
            r_pend_pause <= (r_state == S_WRITE) & i_pause;

            if (r_state == S_IDLE && i_start) begin
                r_fin  <= 1'b0;
                r_addr <= '0;
            end

            if (w_next == S_SHIFT && r_state != S_SHIFT) begin
                r_bitcnt <= '0;
                r_skip   <= 1'b1;
            end else if (r_state == S_SHIFT && w_bclk_rise) begin
                // First rise after the LR edge carries no data (I2S one-bit delay).
                if (r_skip) begin
                    r_skip <= 1'b0;
                end else begin
                    r_shift  <= w_shift_in;
                    r_bitcnt <= r_bitcnt + 1'b1;
                end
            end

            if (r_state == S_WRITE) begin
                r_addr <= w_addr_inc;
                if (w_last) begin
                    r_stop_addr <= ADDR_W'(MAX_ADDR);
                    r_fin       <= 1'b1;
                end
            end

            if (w_stop_take) begin
                r_stop_addr <= r_addr;
                r_fin       <= 1'b1;
            end
        end
    end

`ifdef AUD_REC_STEREO_AVG_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_right <= 1'b0;
            r_left  <= '0;
        end else if (w_next == S_IDLE || w_next == S_PAUSE || r_state == S_WRITE) begin
            r_right <= 1'b0;
        end else if (w_word_done && !r_right) begin
            r_left  <= w_shift_in;
            r_right <= 1'b1;
        end
    end
`endif

    assign o_we        = (r_state == S_WRITE);
    assign o_address   = r_addr;
    assign o_stop_addr = r_stop_addr;
    assign o_fin       = r_fin;
    assign o_state     = r_state;

endmodule

// File: tb/tb_aud_rec_writer.sv
// Randomised scoreboard bench for aud_rec_writer: frame-level reference model feeds an expected-write queue.
module tb_aud_rec_writer;

    localparam int DW   = 16;
    localparam int AW   = 20;
    localparam int MAXA = 6;

    logic          clk = 1'b0;
    logic          rst, start, pause, stop, bclk, lrck, adcdat;
    logic [AW-1:0] o_address, o_stop_addr;
    logic [DW-1:0] o_data;
    logic          o_we, o_fin;
    logic [2:0]    o_state;

    aud_rec_writer #(.DATA_W(DW), .ADDR_W(AW), .MAX_ADDR(MAXA)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
        .i_bclk(bclk), .i_lrck(lrck), .i_adcdat(adcdat),
        .o_address(o_address), .o_data(o_data), .o_we(o_we),
        .o_stop_addr(o_stop_addr), .o_fin(o_fin), .o_state(o_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0, errors = 0;
    // Reference model: 0 idle, 1 recording, 2 paused
    int  m_mode = 0, m_addr = 0, m_fin = 0, m_stop = 0;

    function automatic logic [DW-1:0] model_word(logic [DW-1:0] l, logic [DW-1:0] r);
`ifdef AUD_REC_STEREO_AVG_EN
        int s;
        s = int'($signed(l)) + int'($signed(r));
        return DW'(s >>> 1);
`else
        return l;
`endif
    endfunction

    function automatic bit is_stereo();
`ifdef AUD_REC_STEREO_AVG_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Control pulses: bit0 start, bit1 pause, bit2 stop; stop > pause > start
    task automatic model_ctl(int k);
        if (k[2]) begin
            if (m_mode != 0) begin m_mode = 0; m_fin = 1; m_stop = m_addr; end
        end else if (k[1]) begin
            if (m_mode == 1) m_mode = 2;
        end else if (k[0]) begin
            if (m_mode == 0) begin m_mode = 1; m_addr = 0; m_fin = 0; end
            else if (m_mode == 2) m_mode = 1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && o_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_we: addr=%0d data=%h, no write expected", o_address, o_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (o_address !== mon_e.a || o_data !== mon_e.d) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%h, want addr=%0d data=%h",
                             o_address, o_data, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive_ctl(int k);
        start = k[0];
        pause = k[1];
        stop  = k[2];
    endtask

    task automatic slot(bit lr, bit d, int lo_k, int hi_k);
        @(negedge clk); bclk = 1'b0; lrck = lr; adcdat = d; drive_ctl(lo_k);
        @(negedge clk); drive_ctl(0);
        repeat (2) @(negedge clk);
        @(negedge clk); bclk = 1'b1;
        @(negedge clk); drive_ctl(hi_k);
        @(negedge clk); drive_ctl(0);
        @(negedge clk);
    endtask

    // 18 bclk slots per half: delay slot, 16 data bits MSB first, pad slot
    task automatic half(bit lr, logic [DW-1:0] w, int first, int last, int ev_slot, int ev_k, bit ev_hi);
        for (int s = first; s <= last; s++) begin
            bit d;
            d = (s >= 1 && s <= 16) ? w[16-s] : 1'b0;
            slot(lr, d, (s == ev_slot && !ev_hi) ? ev_k : 0, (s == ev_slot && ev_hi) ? ev_k : 0);
        end
    endtask

    task automatic status();
        int es;
        es = (m_mode == 0) ? 0 : (m_mode == 1) ? 1 : 4;
        chk("fin", 32'(o_fin), 32'(m_fin));
        chk("state", 32'(o_state), 32'(es));
        if (m_fin != 0) chk("stop_addr", 32'(o_stop_addr), 32'(m_stop));
    endtask

    task automatic frame(logic [DW-1:0] l, logic [DW-1:0] r, int ev_slot = -1, int ev_k = 0, bit ev_hi = 0);
        bit abort;
        wr_t t;
        if (m_mode == 1) begin
            abort = (ev_k[1] || ev_k[2]) && (is_stereo() || !(ev_slot == 16 && ev_hi));
            if (!abort) begin
                t.a = AW'(m_addr);
                t.d = model_word(l, r);
                exp_q.push_back(t);
                m_addr++;
                if (m_addr == MAXA) begin m_mode = 0; m_fin = 1; m_stop = MAXA; end
            end
        end
        model_ctl(ev_k);
        half(1'b0, l, 0, 17, ev_slot, ev_k, ev_hi);
        half(1'b1, r, 0, 17, -1, 0, 1'b0);
        status();
    endtask

    task automatic pulse(int k);
        model_ctl(k);
        @(negedge clk); drive_ctl(k);
        @(negedge clk); drive_ctl(0);
        repeat (2) @(negedge clk);
        status();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, errors=%0d", errors);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 0; pause = 0; stop = 0; bclk = 0; lrck = 1; adcdat = 0;
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(o_we), 0);
        chk("rst_state", 32'(o_state), 0);
        chk("rst_fin", 32'(o_fin), 0);
        chk("rst_addr", 32'(o_address), 0);
        rst = 1'b0;

        // Reset mid-shift: asynchronous clear, partial word lost
        pulse(1);
        half(1'b0, 16'hBEEF, 0, 8, -1, 0, 1'b0);
        @(negedge clk); #1 rst = 1'b1; #1;
        chk("arst_state", 32'(o_state), 0);
        chk("arst_we", 32'(o_we), 0);
        chk("arst_data", 32'(o_data), 0);
        chk("arst_addr", 32'(o_address), 0);
        chk("arst_stop", 32'(o_stop_addr), 0);
        chk("arst_fin", 32'(o_fin), 0);
        m_mode = 0; m_fin = 0; m_stop = 0; m_addr = 0;
        @(negedge clk); rst = 1'b0;
        half(1'b0, 16'hBEEF, 9, 17, -1, 0, 1'b0);
        half(1'b1, 16'h0000, 0, 17, -1, 0, 1'b0);
        status();

        // Three frames then stop
        pulse(1);
        frame(16'h8001, 16'h1111);
        frame(16'h7FFE, 16'h2222);
        frame(16'h0F0F, 16'h3333);
        pulse(4);

        // Pause mid-word, idle frames, resume at retained address
        pulse(1);
        frame(16'hAAAA, 16'h0001);
        frame(16'h5555, 16'h0002, 9, 2, 1'b0);
        frame(16'h6666, 16'h0003);
        frame(16'h7777, 16'h0004);
        pulse(1);
        frame(16'h1234, 16'h0005);
        pulse(4);

        // Stop+pause coinciding with the write strobe
        pulse(1);
        frame(16'h1111, 16'h4444);
        frame(16'h2222, 16'h5555, 16, 6, 1'b1);

        // Averaging corner values
        pulse(1);
        frame(16'h0100, 16'hFF00);
        frame(16'h7FFF, 16'h7FFF);
        frame(16'h8000, 16'h8000);
        pulse(4);

        // Capacity limit: auto-finish then no further writes
        pulse(1);
        for (int i = 0; i < MAXA + 2; i++) frame(DW'($urandom), DW'($urandom));

        // Randomised traffic
        for (int i = 0; i < 30; i++) begin
            int r;
            if (m_mode != 1 && ($urandom % 2) == 0) pulse(1);
            r = $urandom % 5;
            if (r == 0)
                frame(DW'($urandom), DW'($urandom), 1 + int'($urandom % 16),
                      (($urandom % 2) == 0) ? 2 : 4, 1'($urandom % 2));
            else
                frame(DW'($urandom), DW'($urandom));
        end

        repeat (20) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aud_rec_writer.md
Name: aud_rec_writer

Overview:
- Record-side counterpart of the playback DSP path.
- Deserialises 16-bit I2S samples from the codec ADC lines (BCLK, ADCLRCK, ADCDAT), all oversampled by the system clock.
- Writes each completed sample to SRAM at consecutive addresses.
- Reports the recorded length as the stop address that the playback path consumes later.
- Start/pause/stop control comes from the top-level FSM.

Parameters:
DATA_W, 16, sample width in bits (MSB first on the serial line)
ADDR_W, 20, SRAM address width
MAX_ADDR, 1024000, capacity in samples; recording auto-finishes when this many samples are written

Ports:
i_clk  input  1  system clock; must be at least 4x i_bclk
i_rst  input  1  reset, asynchronous, active-high
i_start  input  1  one-cycle pulse: begin (IDLE) or resume (PAUSE)
i_pause  input  1  one-cycle pulse: pause recording
i_stop  input  1  one-cycle pulse: end recording
i_bclk  input  1  codec bit clock, already synchronous to i_clk
i_lrck  input  1  codec ADCLRCK; low = left channel
i_adcdat  input  1  codec serial ADC data
o_address  output  ADDR_W  SRAM write address
o_data  output  DATA_W  SRAM write data
o_we  output  1  SRAM write strobe, one cycle per sample
o_stop_addr  output  ADDR_W  number of samples recorded, valid while o_fin=1
o_fin  output  1  level; set on finish, cleared by the next i_start in IDLE
o_state  output  3  current FSM state encoding

Behaviour:
- Reset: clock is i_clk; reset is asynchronous and active-high (i_rst). All outputs are 0, the state is S_IDLE, and the edge registers for i_bclk/i_lrck are 0.
- Reset mid-operation aborts immediately. No o_we is issued, and the partial sample is lost.
- Edge detection: previous i_bclk and i_lrck values are registered every cycle.
  - bclk_rise = ~prev & cur.
  - lrck_fall = prev & ~cur.
- States and encodings: S_IDLE=0, S_WAIT=1, S_SHIFT=2, S_WRITE=3, S_PAUSE=4.
- S_IDLE:
  - On i_start: o_fin<=0, address<=0, go to S_WAIT.
  - Otherwise hold. o_address and o_stop_addr keep their last values.
- S_WAIT:
  - On lrck_fall: bit counter<=0, skip flag<=1, go to S_SHIFT.
- S_SHIFT (I2S one-bit delay):
  - The first bclk_rise after lrck_fall is discarded.
  - Each of the next 16 bclk_rise events shifts i_adcdat into the LSB of the shift register (the MSB arrives first).
  - After the 16th capture, go to S_WRITE.
- S_WRITE (exactly one cycle):
  - o_we=1, o_data=shift register, o_address=current address.
  - Next cycle: address<=address+1.
  - If address+1 == MAX_ADDR: go to S_IDLE, o_stop_addr<=MAX_ADDR, o_fin<=1.
  - Else go to S_WAIT.
- o_we is 0 in every state except S_WRITE.
- Control priority when pulses coincide: stop > pause > start.
- i_stop in S_WAIT, S_SHIFT or S_PAUSE:
  - Go to S_IDLE; any partial sample is discarded.
  - o_stop_addr<=address (samples fully written); o_fin<=1.
- i_pause in S_WAIT or S_SHIFT: go to S_PAUSE, discard the partial sample, retain the address.
- Pulses during S_WRITE: i_stop/i_pause are latched into pending flags. They take effect in the cycle after the write, with stop taking priority, and the written sample counts.
- S_PAUSE:
  - i_start: go to S_WAIT and resume at the retained address.
  - i_stop: as above.
- i_start in S_WAIT, S_SHIFT or S_WRITE is ignored.
- Address arithmetic is unsigned ADDR_W. Wrap-around cannot occur because MAX_ADDR terminates recording first.
- Latency: o_we asserts 1 i_clk cycle after the bclk_rise that captured the LSB.

Optional Feature:
- Macro: AUD_REC_STEREO_AVG_EN.
- When defined:
  - After the left word, the block also captures the right word: it waits for the lrck rise, skips one bclk_rise, then captures 16 bits.
  - It writes a single sample: (signed(L)+signed(R))>>>1, computed at 17 bits and truncated to 16.
  - Pause/stop during the right-word capture discards both words.
- When undefined: only the left channel is recorded, and the right half-frame is ignored.

Test Plan:
1. Reset with i_rst=1 mid-S_SHIFT -> all outputs 0 and o_state=0 asynchronously; no o_we after release.
2. i_start, then 3 I2S frames with left words 16'h8001, 16'h7FFE, 16'h0F0F -> three one-cycle o_we pulses at addresses 0,1,2 with those data; then i_stop -> o_fin=1, o_stop_addr=3.
3. i_pause after 8 bits of the 2nd frame, then i_start two frames later, then the next frame 16'h1234 -> address 1 is written with 16'h1234; the partial sample is never written.
4. MAX_ADDR=4 override, continuous frames -> writes at addresses 0..3, then o_fin=1, o_stop_addr=4, o_state=0, no further o_we.
5. i_stop and i_pause asserted in the same cycle as o_we -> the write at that address completes, then the block goes to S_IDLE with o_stop_addr=address+1 and o_fin=1.
6. With AUD_REC_STEREO_AVG_EN, L=16'h0100 and R=16'hFF00 (-256) -> o_data=16'h0000; L=16'h7FFF and R=16'h7FFF -> o_data=16'h7FFF.
